// File: rtl/ps2_device_tx_if.sv
// Byte handshake and open-drain PS/2 line bundle for the device-side transmitter.
// The slave modport is the transmitter; the master modport is the byte source and the bus.
interface ps2_device_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_abort;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        input  tx_ready, tx_done, tx_abort, busy, ps2_clk_oe, ps2_dat_oe
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
        output tx_ready, tx_done, tx_abort, busy, ps2_clk_oe, ps2_dat_oe
    );
endinterface

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: serializes accepted bytes as 11-bit frames, generating
// the PS/2 clock itself and backing off (abort + full retransmit) on host inhibit.
module ps2_device_tx #(
    parameter int unsigned HALF_CYC     = 2000,
    parameter int unsigned IDLE_GAP_CYC = 2500
) (
    input logic            clk_clk,
    input logic            reset_reset,
    ps2_device_tx_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StWait, StHigh, StLow, StDone} state_e;

    localparam int unsigned CntMax = (IDLE_GAP_CYC > HALF_CYC) ? IDLE_GAP_CYC : HALF_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] GapLast  = CntW'(IDLE_GAP_CYC - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_CYC - 1);
    localparam logic [CntW-1:0] HalfMid  = CntW'(HALF_CYC / 2);
    localparam logic [CntW-1:0] Settle   = CntW'(2);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [10:0]     shift_q, shift_d;
    logic            clk_oe_q, clk_oe_d;
    logic            dat_oe_q, dat_oe_d;
    logic            abort_q, abort_d;
    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            clk_s, dat_s;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Idle bus reads high, so the synchronizers reset to 1.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_dat_in};
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        abort_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d    = '0;
                idx_d    = '0;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (bus.tx_valid) begin
                    shift_d = {1'b1, ~^bus.tx_data, bus.tx_data, 1'b0};
                    state_d = StWait;
                end
            end
            StWait: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (clk_s && dat_s) begin
                    if (cnt_q == GapLast) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = StHigh;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            StHigh: begin
                // The first two cycles still see the clock we were driving low.
                if (cnt_q >= Settle && !clk_s) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    abort_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = StWait;
                end else begin
                    if (cnt_q == HalfMid) begin
                        dat_oe_d = ~shift_q[idx_q];
                    end
                    if (cnt_q == HalfLast) begin
                        cnt_d    = '0;
                        clk_oe_d = 1'b1;
                        state_d  = StLow;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
            StLow: begin
                if (cnt_q == HalfLast) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    if (idx_q == 4'd10) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StHigh;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StDone: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.tx_ready   = (state_q == StIdle);
    assign bus.tx_done    = (state_q == StDone);
    assign bus.tx_abort   = abort_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.ps2_clk_oe = clk_oe_q;
    assign bus.ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: pull-up bus model, host-side frame sampler and a
// frame-level reference model derived from the PS/2 framing rules.
module tb_ps2_device_tx;

    localparam int unsigned HalfCyc = 8;
    localparam int unsigned GapCyc  = 20;
    localparam int unsigned LatLo   = 2 + GapCyc + 22 * HalfCyc - 2;
    localparam int unsigned LatHi   = 2 + GapCyc + 22 * HalfCyc + 2;

    logic clk_clk     = 1'b0;
    logic reset_reset = 1'b1;
    logic host_clk_low = 1'b0;
    logic host_dat_low = 1'b0;

    ps2_device_tx_if bus ();

    // Open-drain lines with pull-ups: low if either side pulls.
    assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | host_clk_low);
    assign bus.ps2_dat_in = ~(bus.ps2_dat_oe | host_dat_low);

    ps2_device_tx #(
        .HALF_CYC    (HalfCyc),
        .IDLE_GAP_CYC(GapCyc)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .bus        (bus)
    );

    always #5 clk_clk = ~clk_clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Host-side monitor state.
    int unsigned cyc = 0;
    logic        clk_prev = 1'b1;
    logic        dut_low = 1'b0;
    int unsigned fall_t = 0, rise_t = 0;
    logic [10:0] bits = '0;
    int unsigned nbits = 0;
    logic [10:0] frames_q[$];
    logic [7:0]  acc_q[$];
    int unsigned acc_t = 0, done_t = 0;
    int unsigned done_cnt = 0, abort_cnt = 0, lo_bad = 0, hi_bad = 0, len_bad = 0;

    always @(negedge clk_clk) begin
        cyc++;
        if (reset_reset) begin
            nbits   = 0;
            dut_low = 1'b0;
        end else begin
            if (bus.tx_valid && bus.tx_ready) begin
                acc_q.push_back(bus.tx_data);
                acc_t = cyc;
            end
            if (clk_prev && !bus.ps2_clk_in && !host_clk_low) begin
                if (nbits > 0 && nbits < 11 && (cyc - rise_t) != HalfCyc) hi_bad++;
                if (nbits < 11) bits[nbits] = bus.ps2_dat_in;
                nbits++;
                dut_low = 1'b1;
                fall_t  = cyc;
            end
            if (!clk_prev && bus.ps2_clk_in && dut_low) begin
                if ((cyc - fall_t) != HalfCyc) lo_bad++;
                dut_low = 1'b0;
                rise_t  = cyc;
            end
            if (bus.tx_abort) begin
                abort_cnt++;
                nbits = 0;
            end
            if (bus.tx_done) begin
                done_cnt++;
                done_t = cyc;
                if (nbits != 11) len_bad++;
                frames_q.push_back(bits);
                nbits = 0;
            end
        end
        clk_prev = bus.ps2_clk_in;
    end

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int unsigned act,
                               input int unsigned lo, input int unsigned hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int unsigned n0 = acc_q.size();
        int unsigned t  = 0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        while (acc_q.size() == n0 && t < 400) begin
            tick();
            t++;
        end
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        if (acc_q.size() == n0) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input int unsigned target);
        int unsigned t = 0;
        while (done_cnt < target && t < 600) begin
            tick();
            t++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    task automatic frame_checks(input string name, input logic [10:0] exp,
                                input int unsigned target, input bit chk_lat);
        wait_done(target);
        tick();
        check({name, "_idle"}, {bus.tx_ready, bus.ps2_clk_oe, bus.ps2_dat_oe}, 3'b100);
        if (chk_lat) check_range({name, "_latency"}, done_t - acc_t, LatLo, LatHi);
        check({name, "_nframes"}, frames_q.size(), 1);
        if (frames_q.size() != 0) check({name, "_frame"}, frames_q.pop_front(), exp);
        check({name, "_lowlen"}, lo_bad, 0);
        check({name, "_highlen"}, hi_bad, 0);
        check({name, "_nbits"}, len_bad, 0);
        lo_bad  = 0;
        hi_bad  = 0;
        len_bad = 0;
        tick(5);
        check({name, "_onedone"}, done_cnt, target);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int unsigned d0, n0, t;
        logic        drove;
        int unsigned rel_t;
        logic [7:0]  rb;

        // Frame bit i (sent i-th) is bit i of exp: start, data LSB-first, odd parity, stop.
        vecs[0] = '{data: 8'h1C, exp: 11'b1_0_00011100_0};
        vecs[1] = '{data: 8'h00, exp: 11'b1_1_00000000_0};
        vecs[2] = '{data: 8'hFF, exp: 11'b1_1_11111111_0};
        vecs[3] = '{data: 8'h5A, exp: 11'b1_1_01011010_0};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        tick(3);
        check("reset_outputs",
              {bus.tx_ready, bus.tx_done, bus.tx_abort, bus.busy, bus.ps2_clk_oe, bus.ps2_dat_oe},
              6'b100000);
        reset_reset = 1'b0;
        tick(2);

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data);
            tick();
            check("busy_after_accept", bus.busy, 1'b1);
            frame_checks($sformatf("vec%0d", i), vecs[i].exp, done_cnt + 1, 1'b1);
        end

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            tick($urandom_range(0, 5));
            send(rb);
            frame_checks($sformatf("rand%0d_%02h", i, rb), frame_of(rb), done_cnt + 1, 1'b1);
        end

        // Host holds CLK low before and during acceptance.
        host_clk_low = 1'b1;
        tick(2);
        send(8'h5A);
        drove = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            drove |= bus.ps2_clk_oe | bus.ps2_dat_oe;
        end
        check("inhibit_nodrive", drove, 1'b0);
        host_clk_low = 1'b0;
        rel_t = cyc;
        t = 0;
        while (!(bus.ps2_clk_oe || bus.ps2_dat_oe) && t < 100) begin
            tick();
            t++;
        end
        check_range("inhibit_first_drive", cyc - rel_t, GapCyc + 2, GapCyc + 2 + HalfCyc);
        frame_checks("pre_inhibit", frame_of(8'h5A), done_cnt + 1, 1'b0);
        check("pre_inhibit_noabort", abort_cnt, 0);

        // Host inhibits during the HIGH phase of bit 4.
        d0 = done_cnt;
        send(8'h5A);
        t = 0;
        while (nbits < 4 && t < 400) begin
            tick();
            t++;
        end
        t = 0;
        while (bus.ps2_clk_oe && t < 20) begin
            tick();
            t++;
        end
        check("bit4_reached", nbits, 4);
        tick(3);
        host_clk_low = 1'b1;
        t = 0;
        while (abort_cnt == 0 && t < 10) begin
            tick();
            t++;
        end
        tick();
        check("abort_release", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 2'b00);
        check("abort_nodone", done_cnt, d0);
        tick(30);
        host_clk_low = 1'b0;
        frame_checks("retransmit", frame_of(8'h5A), d0 + 1, 1'b0);
        check("abort_once", abort_cnt, 1);

        // Reset during the clock-low phase of bit 6.
        d0 = done_cnt;
        send(8'h0F);
        t = 0;
        while (nbits < 7 && t < 400) begin
            tick();
            t++;
        end
        tick(2);
        check("pre_reset_driving", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 2'b11);
        reset_reset = 1'b1;
        #1;
        check("reset_async_release", {bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_ready}, 3'b001);
        tick(3);
        reset_reset = 1'b0;
        tick(2);
        check("post_reset_state", {bus.tx_ready, bus.busy}, 2'b10);
        tick(300);
        check("reset_nodone", done_cnt, d0);
        lo_bad = 0;
        hi_bad = 0;
        send(8'h33);
        frame_checks("after_reset", frame_of(8'h33), d0 + 1, 1'b1);

        // Back-to-back with tx_valid held high.
        d0 = done_cnt;
        n0 = acc_q.size();
        bus.tx_data  = 8'hAA;
        bus.tx_valid = 1'b1;
        t = 0;
        while (acc_q.size() < n0 + 1 && t < 50) begin
            tick();
            t++;
        end
        bus.tx_data = 8'h55;
        t = 0;
        while (acc_q.size() < n0 + 2 && t < 600) begin
            tick();
            t++;
        end
        check("b2b_second_after_done", done_cnt, d0 + 1);
        bus.tx_valid = 1'b0;
        wait_done(d0 + 2);
        tick(50);
        check("b2b_done_count", done_cnt, d0 + 2);
        check("b2b_accept_count", acc_q.size(), n0 + 2);
        check("b2b_nframes", frames_q.size(), 2);
        if (frames_q.size() >= 2) begin
            check("b2b_frame0", frames_q.pop_front(), frame_of(8'hAA));
            check("b2b_frame1", frames_q.pop_front(), frame_of(8'h55));
        end
        if (acc_q.size() >= 2) begin
            check("b2b_acc_order", {acc_q[acc_q.size() - 2], acc_q[acc_q.size() - 1]}, 16'hAA55);
        end
        check("b2b_lens", lo_bad + hi_bad + len_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
PS/2 device-side transmitter: the keyboard/mouse end of the PS/2 link that the system's PS/2 host port listens to. It accepts bytes over a valid/ready handshake and serializes each one as an 11-bit PS/2 frame. The block generates the PS/2 clock itself and drives both lines open-drain. It honours host inhibit by aborting and retransmitting. It serves as a keystroke/scancode source for board-level and simulation testing of the host side.

Parameters:
HALF_CYC, 2000, system-clock cycles per PS/2 clock half-period (40 us at 50 MHz); must be ≥4 and even
IDLE_GAP_CYC, 2500, consecutive cycles both lines must read high before a frame may start

Ports:
clk_clk  input  1  system clock
reset_reset  input  1  asynchronous reset, active-high
tx_data  input  8  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a byte
tx_done  output  1  one-cycle pulse: frame completed
tx_abort  output  1  one-cycle pulse: frame aborted by host inhibit (retry follows)
busy  output  1  byte held, frame pending or in progress
ps2_clk_in  input  1  PS/2 CLK line level (asynchronous)
ps2_dat_in  input  1  PS/2 DAT line level (asynchronous)
ps2_clk_oe  output  1  1 = pull CLK low, 0 = release
ps2_dat_oe  output  1  1 = pull DAT low, 0 = release

Behaviour:
- Reset (async, while asserted): state IDLE. tx_ready=1, tx_done=0, tx_abort=0, busy=0, ps2_clk_oe=0, ps2_dat_oe=0. All counters are cleared and the held byte is discarded. If reset is asserted mid-frame, both lines are released immediately.
- Synchronize ps2_clk_in and ps2_dat_in through 2 flops; all decisions use the synchronized values.
- Handshake: a byte is accepted when tx_valid && tx_ready. tx_ready = (state==IDLE). On acceptance, latch shift register = {1'b1 stop, ~^tx_data odd parity, tx_data, 1'b0 start}, sent LSB-first. busy goes high the cycle after acceptance.
- WAIT_BUS: count cycles with clk_sync==1 && dat_sync==1. Any low sample resets the count (this covers host inhibit or host request-to-send). When the count reaches IDLE_GAP_CYC, go to HIGH with bit index 0.
- HIGH: lasts HALF_CYC cycles with the clock released. At cycle HALF_CYC/2 of this phase, set ps2_dat_oe = ~current bit. Then go to LOW.
- LOW: lasts HALF_CYC cycles with ps2_clk_oe=1. The host samples data on the falling edge. At the end, release the clock. If bit index==10, go to DONE; otherwise increment the index and go to HIGH.
- Inhibit: during HIGH (after a 2-cycle settling window following clock release), clk_sync==0 means the host is inhibiting. Response:
  - release both lines;
  - pulse tx_abort;
  - keep the byte;
  - go to WAIT_BUS and retransmit the whole frame from the start bit.
  Inhibit is not checked during LOW.
- DONE: one cycle. Release both lines, pulse tx_done, then go to IDLE. tx_ready returns to 1 on the next cycle.
- Frame time from acceptance with no inhibit: 2 (sync) + IDLE_GAP_CYC + 22*HALF_CYC cycles, ±2.
- tx_valid while busy is ignored; tx_data does not need to stay stable after acceptance.
- If tx_done and a new tx_valid occur together, the byte is not accepted that cycle.

Test Plan:
- Bench uses HALF_CYC=8, IDLE_GAP_CYC=20, with a pull-up bus model. Send 0x1C → host-side sampler sees 11 falling edges with DAT = 0,0,0,1,1,1,0,0,0,0,1 (start, data LSB-first, parity 0, stop). Then one tx_done pulse, lines released, and tx_ready=1.
- Send 0x00 → parity bit 1. Send 0xFF → parity bit 1. Each frame has 11 clock lows of exactly 8 cycles; highs are 8 cycles.
- Host holds CLK low when 0x5A is accepted → no DAT/CLK drive until CLK has been high for 20 cycles. The frame then completes correctly.
- Host pulls CLK low during the HIGH phase of bit 4 → tx_abort pulses once and both lines are released. After CLK is released plus 20 idle cycles, the full 0x5A frame is resent from the start bit, followed by a single tx_done.
- Assert reset_reset during bit 6 of a frame → ps2_clk_oe=ps2_dat_oe=0 immediately and tx_ready=1 after release. tx_done never pulses, and the next byte 0x33 transmits normally.
- Hold tx_valid high with 0xAA then 0x55 back-to-back → exactly two frames, in order. The second byte is accepted only after tx_done, and no byte is dropped or duplicated.
